// File: rtl/note_scheduler.sv
// Note-index sequencer for the tone path: live keys preempt a ROM-driven auto-play song,
// which freezes while overridden and resumes from the exact tick it was interrupted at.
module note_scheduler #(
    parameter int TICK_DIV = 3000000,
    parameter int GAP_CYC  = 600000,
    parameter int ADDR_W   = 6,
    parameter int SONG_LEN = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [14:0]       KEY,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [7:0]        ROM_DATA,
    output logic [3:0]        INX,
    output logic              BUSY,
    output logic              PAUSED,
    output logic              DONE
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [3:0]        note_q, note_n;
    logic [3:0]        dur_q, dur_n;
    logic [3:0]        inx_q, inx_n;
    logic [3:0]        manual_note;
    logic [TICK_W-1:0] tick_q, tick_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [14:0]       key_s1, key_s2;
    logic              manual_active;
    logic              done_q, done_n;
    logic              advance, song_end;

    // KEY is asynchronous to CLK; nothing downstream looks at it before the second flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
        end
    end

    assign manual_active = |key_s2;

    // Highest pressed index wins, so later iterations override earlier ones.
    always_comb begin
        manual_note = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (key_s2[i]) manual_note = 4'(i + 1);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n  = state_q;
        addr_n   = addr_q;
        note_n   = note_q;
        dur_n    = dur_q;
        tick_n   = tick_q;
        gap_n    = gap_q;
        done_n   = 1'b0;
        advance  = 1'b0;
        song_end = 1'b0;

        if (STOP && state_q != S_IDLE) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !STOP) begin
                        addr_n  = '0;
                        state_n = S_FETCH;
                    end
                end
                S_FETCH: state_n = S_LOAD;
                S_LOAD: begin
                    if (ROM_DATA[3:0] == 4'd0) begin
                        song_end = 1'b1;
                    end else begin
                        note_n  = ROM_DATA[7:4];
                        dur_n   = ROM_DATA[3:0];
                        tick_n  = '0;
                        state_n = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // A held key freezes tick and duration so the note resumes mid-way.
                    if (!manual_active) begin
                        if (tick_q == TICK_LAST) begin
                            tick_n = '0;
                            if (dur_q == 4'd1) begin
                                dur_n = 4'd0;
                                if (GAP_CYC > 0) begin
                                    gap_n   = '0;
                                    state_n = S_GAP;
                                end else begin
                                    advance = 1'b1;
                                end
                            end else begin
                                dur_n = dur_q - 4'd1;
                            end
                        end else begin
                            tick_n = tick_q + TICK_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!manual_active) begin
                        if (gap_q == GAP_LAST) advance = 1'b1;
                        else                   gap_n   = gap_q + GAP_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                if (LOOP) begin
                    addr_n  = '0;
                    state_n = S_FETCH;
                end else begin
                    song_end = 1'b1;
                end
            end else begin
                addr_n  = addr_q + ADDR_W'(1);
                state_n = S_FETCH;
            end
        end

        if (song_end) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
        end

        // INX is driven from next-state values so the auto note lines up exactly with PLAY.
        inx_n = manual_active ? manual_note : ((state_n == S_PLAY) ? note_n : 4'd0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            note_q  <= 4'd0;
            dur_q   <= 4'd0;
            tick_q  <= '0;
            gap_q   <= '0;
            inx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_n;
            addr_q  <= addr_n;
            note_q  <= note_n;
            dur_q   <= dur_n;
            tick_q  <= tick_n;
            gap_q   <= gap_n;
            inx_q   <= inx_n;
            done_q  <= done_n;
        end
    end

    assign ROM_ADDR = addr_q;
    assign INX      = inx_q;
    assign DONE     = done_q;
    assign BUSY     = (state_q != S_IDLE);
    assign PAUSED   = manual_active && (state_q == S_PLAY || state_q == S_GAP);

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a cycle-countdown reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized songs and key traffic.
module tb_note_scheduler;

    localparam int TICK_DIV = 4;
    localparam int GAP_CYC  = 2;
    localparam int ADDR_W   = 6;
    localparam int SONG_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [14:0]       key = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_mode = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'h00;
    logic [3:0]        inx;
    logic              busy, paused, done;

    logic [7:0] rom [4];

    int tests = 0;
    int fails = 0;
    int cnt5 = 0, cnt3 = 0, cnt7 = 0, done_cnt = 0, busy_cyc = 0;
    int b5, b3, bdone, bbusy;

    note_scheduler #(
        .TICK_DIV(TICK_DIV),
        .GAP_CYC (GAP_CYC),
        .ADDR_W  (ADDR_W),
        .SONG_LEN(SONG_LEN)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .KEY     (key),
        .START   (start),
        .STOP    (stop),
        .LOOP    (loop_mode),
        .ROM_ADDR(rom_addr),
        .ROM_DATA(rom_data),
        .INX     (inx),
        .BUSY    (busy),
        .PAUSED  (paused),
        .DONE    (done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Notes are tracked as a total count of unpaused cycles (duration*TICK_DIV), gaps likewise.
    typedef enum logic [2:0] {P_IDLE, P_FETCH, P_LOAD, P_PLAY, P_GAP} phase_t;

    phase_t      m_ph = P_IDLE;
    logic [5:0]  m_addr = '0;
    logic [3:0]  m_note = '0;
    logic [3:0]  m_inx = '0;
    logic        m_done = 1'b0;
    logic        m_act = 1'b0;
    logic [7:0]  m_e = '0;
    logic [14:0] m_k1 = '0, m_k2 = '0;
    int          m_left = 0, m_gap = 0;

    function automatic logic [3:0] top_note(input logic [14:0] k);
        for (int i = 14; i >= 0; i--) begin
            if (k[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    task end_song();
        m_ph   = P_IDLE;
        m_done = 1'b1;
    endtask

    task next_entry();
        if (m_addr == 6'(SONG_LEN - 1)) begin
            if (loop_mode) begin
                m_addr = '0;
                m_ph   = P_FETCH;
            end else begin
                end_song();
            end
        end else begin
            m_addr = m_addr + 6'd1;
            m_ph   = P_FETCH;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = P_IDLE; m_addr = '0; m_note = '0; m_inx = '0; m_done = 1'b0;
                m_k1 = '0; m_k2 = '0; m_left = 0; m_gap = 0;
            end else begin
                m_act  = (m_k2 != 0);
                m_done = 1'b0;
                if (stop && m_ph != P_IDLE) begin
                    m_ph   = P_IDLE;
                    m_done = 1'b1;
                end else begin
                    case (m_ph)
                        P_IDLE: if (start && !stop) begin
                            m_addr = '0;
                            m_ph   = P_FETCH;
                        end
                        P_FETCH: m_ph = P_LOAD;
                        P_LOAD: begin
                            m_e = rom[m_addr[1:0]];
                            if (m_e[3:0] == 4'd0) end_song();
                            else begin
                                m_note = m_e[7:4];
                                m_left = int'(m_e[3:0]) * TICK_DIV;
                                m_ph   = P_PLAY;
                            end
                        end
                        P_PLAY: if (!m_act) begin
                            m_left--;
                            if (m_left == 0) begin
                                if (GAP_CYC > 0) begin
                                    m_gap = GAP_CYC;
                                    m_ph  = P_GAP;
                                end else next_entry();
                            end
                        end
                        P_GAP: if (!m_act) begin
                            m_gap--;
                            if (m_gap == 0) next_entry();
                        end
                        default: m_ph = P_IDLE;
                    endcase
                end
                m_inx = m_act ? top_note(m_k2) : ((m_ph == P_PLAY) ? m_note : 4'd0);
                m_k2  = m_k1;
                m_k1  = key;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("inx", 32'(inx), 32'(m_inx));
                check("rom_addr", 32'(rom_addr), 32'(m_addr));
                check("busy", 32'(busy), 32'(m_ph != P_IDLE));
                check("paused", 32'(paused), 32'((m_k2 != 0) && (m_ph == P_PLAY || m_ph == P_GAP)));
                check("done", 32'(done), 32'(m_done));
                if (inx == 4'd5) cnt5++;
                if (inx == 4'd3) cnt3++;
                if (inx == 4'd7) cnt7++;
                if (done) done_cnt++;
                if (busy) busy_cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic set_rom(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    initial begin
        set_rom(8'h52, 8'h31, 8'h01, 8'h00);
        step(3);
        check("rst_inx", 32'(inx), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        step(3);

        // Plain song: 5 for 8 cycles, 3 for 4, timed rest, end marker.
        b5 = cnt5; b3 = cnt3; bdone = done_cnt; bbusy = busy_cyc;
        pulse_start();
        step(40);
        check("s1_inx5_cycles", 32'(cnt5 - b5), 32'd8);
        check("s1_inx3_cycles", 32'(cnt3 - b3), 32'd4);
        check("s1_done_pulses", 32'(done_cnt - bdone), 32'd1);
        check("s1_busy_cycles", 32'(busy_cyc - bbusy), 32'd30);
        check("s1_last_addr", 32'(rom_addr), 32'd3);
        check("s1_busy_end", 32'(busy), 32'd0);

        // Looping song wraps back to entry 0.
        set_rom(8'h52, 8'h31, 8'h71, 8'h12);
        loop_mode = 1'b1;
        pulse_start();
        step(44);
        check("loop_addr", 32'(rom_addr), 32'd0);
        check("loop_inx", 32'(inx), 32'd5);
        check("loop_busy", 32'(busy), 32'd1);
        pulse_stop();
        check("loop_stop_done", 32'(done), 32'd1);
        step(1);
        check("loop_stop_done_low", 32'(done), 32'd0);
        loop_mode = 1'b0;
        step(2);

        // Override during note 5: pause, show 7, resume with the remaining time.
        set_rom(8'h52, 8'h31, 8'h01, 8'h00);
        b5 = cnt5; bdone = done_cnt;
        pulse_start();
        step(2);
        key = 15'h0040;
        step(3);
        check("ovr_inx7", 32'(inx), 32'd7);
        check("ovr_paused", 32'(paused), 32'd1);
        check("ovr_busy", 32'(busy), 32'd1);
        step(17);
        check("ovr_inx5_before", 32'(cnt5 - b5), 32'd3);
        key = '0;
        b5 = cnt5;
        step(30);
        check("ovr_inx5_after", 32'(cnt5 - b5), 32'd5);
        check("ovr_done_pulses", 32'(done_cnt - bdone), 32'd1);

        // Manual priority while idle.
        key = 15'h0802;
        step(3);
        check("man_inx12", 32'(inx), 32'd12);
        check("man_busy", 32'(busy), 32'd0);
        key = 15'h0002;
        step(3);
        check("man_inx2", 32'(inx), 32'd2);
        key = 15'h4004;
        step(3);
        check("man_inx15", 32'(inx), 32'd15);
        key = '0;
        step(3);
        check("man_inx0", 32'(inx), 32'd0);

        // STOP in the gap after note 5.
        pulse_start();
        step(10);
        check("gap_inx", 32'(inx), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        pulse_stop();
        check("gapstop_busy", 32'(busy), 32'd0);
        check("gapstop_done", 32'(done), 32'd1);
        step(1);
        check("gapstop_done_low", 32'(done), 32'd0);

        // STOP while paused by a key.
        pulse_start();
        step(2);
        key = 15'h0001;
        step(5);
        check("pstop_paused_before", 32'(paused), 32'd1);
        pulse_stop();
        check("pstop_paused", 32'(paused), 32'd0);
        check("pstop_busy", 32'(busy), 32'd0);
        check("pstop_done", 32'(done), 32'd1);
        check("pstop_inx_manual", 32'(inx), 32'd1);
        key = '0;
        step(5);

        // START and STOP together from idle: nothing happens.
        bdone = done_cnt; bbusy = busy_cyc;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(3);
        check("ss_busy_cycles", 32'(busy_cyc - bbusy), 32'd0);
        check("ss_done_pulses", 32'(done_cnt - bdone), 32'd0);

        // Asynchronous reset in the middle of note 3 (entry 1).
        pulse_start();
        step(14);
        check("ar_inx_before", 32'(inx), 32'd3);
        check("ar_addr_before", 32'(rom_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_inx", 32'(inx), 32'd0);
        check("ar_addr", 32'(rom_addr), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_paused", 32'(paused), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        #3 rst_n = 1'b1;
        bbusy = busy_cyc;
        step(10);
        check("ar_no_resume", 32'(busy_cyc - bbusy), 32'd0);

        // Randomized songs, keys and control pulses against the model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                rom[i] = {4'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3))};
            end
            loop_mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 1200; c++) begin
                start = ($urandom_range(0, 39) == 0);
                stop  = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 29) == 0) begin
                    if ($urandom_range(0, 1) == 0) key = '0;
                    else if ($urandom_range(0, 3) == 0) key = 15'($urandom);
                    else key = 15'(1 << $urandom_range(0, 14));
                end
                if ($urandom_range(0, 499) == 0) loop_mode = ~loop_mode;
                step(1);
            end
            start = 1'b0;
            key = '0;
            pulse_stop();
            step(3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences the single note-index input of the tone path: note-to-divider-preset decoder, then the speaker divider.
- Shares that path between two requesters: the live keyboard and an auto-play song stored in an external synchronous ROM.
- Live keys always preempt auto-play. Auto-play pauses and resumes at the exact point it was interrupted.
- Output INX drives the decoder directly; value 0 means rest/silence.

Parameters:
- TICK_DIV, 3000000: clock cycles per duration tick (4 Hz at 12 MHz).
- GAP_CYC, 600000: silent cycles inserted after every auto note; 0 = no gap.
- ADDR_W, 6: song ROM address width.
- SONG_LEN, 64: number of ROM entries used; last address = SONG_LEN-1.

Ports:
- CLK, input, 1: system clock, rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- KEY, input, 15: raw key levels, KEY[i-1] requests note index i (1..15), active-high, asynchronous.
- START, input, 1: single-cycle pulse, begins auto-play at address 0.
- STOP, input, 1: single-cycle pulse, aborts auto-play.
- LOOP, input, 1: 1 = wrap to address 0 after last entry; 0 = finish.
- ROM_ADDR, output, ADDR_W: song ROM address, registered.
- ROM_DATA, input, 8: [7:4] note index, [3:0] duration in ticks; valid one cycle after ROM_ADDR changes.
- INX, output, 4: note index to decoder, registered.
- BUSY, output, 1: auto-play in progress, including while paused.
- PAUSED, output, 1: auto-play frozen by manual override.
- DONE, output, 1: one-cycle pulse at song end or on STOP.

Behaviour:
- **Reset (RST_N=0, asynchronous):**
  - INX=0, ROM_ADDR=0, BUSY=0, PAUSED=0, DONE=0.
  - State IDLE; tick and gap counters cleared; key synchronizers cleared.
  - Reset mid-song abandons the song with no resume.
- **Key path:**
  - KEY passes through a 2-flop synchronizer.
  - manual_active = any synchronized bit set.
  - Manual note = highest set index; KEY[14] and KEY[2] together gives 15.
  - INX reflects a key 3 edges after KEY changes: 2 sync + 1 output register.
- **INX source:**
  - manual_active: manual note.
  - Otherwise in PLAY: latched auto note.
  - Otherwise: 0.
- **Auto state machine (IDLE, FETCH, LOAD, PLAY, GAP):**
  - IDLE: on START, ROM_ADDR<=0, BUSY<=1, go to FETCH.
  - FETCH: one cycle, waiting for ROM_DATA; go to LOAD.
  - LOAD: sample ROM_DATA.
    - Duration 0 is the end marker: treat as song end.
    - Otherwise latch note and duration, clear tick counter, go to PLAY.
    - Note index 0 with nonzero duration is a timed rest.
  - PLAY: tick counter counts 0..TICK_DIV-1; each wrap decrements remaining duration.
    - When remaining reaches 0: go to GAP if GAP_CYC>0, else advance.
    - Total note time is exactly duration*TICK_DIV cycles.
  - GAP: INX=0 for GAP_CYC cycles, then advance.
  - Advance:
    - If ROM_ADDR==SONG_LEN-1 and LOOP=0: song end.
    - If ROM_ADDR==SONG_LEN-1 and LOOP=1: ROM_ADDR<=0, go to FETCH.
    - Otherwise: ROM_ADDR<=ROM_ADDR+1, go to FETCH.
  - Song end: DONE pulses one cycle, BUSY<=0, INX source returns to 0, go to IDLE. ROM_ADDR holds its last value.
- **Pause:**
  - While manual_active and state is PLAY or GAP: PAUSED=1, and tick counter, gap counter and remaining duration freeze.
  - On release: counting resumes from the frozen values with no restart of the note.
  - FETCH and LOAD always complete; a key held there only affects INX.
  - If pause is still active on entry to PLAY, PLAY begins frozen.
- **STOP:**
  - In any non-IDLE state: next edge goes to IDLE, BUSY=0, PAUSED=0, DONE pulses. Applies while paused too.
  - In IDLE: ignored.
- **Simultaneous and repeated START/STOP:**
  - START while BUSY: ignored.
  - START and STOP in the same cycle: STOP wins. From IDLE, nothing starts and there is no DONE.
  - DONE from STOP and DONE from song end never overlap; at most one pulse per song.

Test Plan (TICK_DIV=4, GAP_CYC=2, SONG_LEN=4, ROM = {0x52, 0x31, 0x01, 0x00}):
- **Reset then start:** after reset, pulse START.
  - ROM_ADDR steps 0,1,2,3.
  - INX=5 for 8 cycles, 0 for 2, 3 for 4, 0 for 2, 0 for 4 (rest), 0 for 2.
  - Entry 3 is the end marker: DONE pulses once, BUSY falls.
- **LOOP:** LOOP=1 with ROM {0x52,0x31,0x71,0x12}.
  - After address 3 ROM_ADDR wraps to 0, INX=5 again, BUSY stays 1.
- **Manual override:** assert KEY[6] at 3 cycles into the note-5 PLAY, hold 20 cycles.
  - INX=7 from 3 edges later, PAUSED=1.
  - After release, INX=5 for exactly 5 remaining cycles.
- **Manual priority:** idle, KEY[1] and KEY[11] held.
  - INX=12; release KEY[11], INX=2; release all, INX=0; BUSY stays 0.
- **STOP:** STOP mid-GAP, and STOP during pause.
  - Both: IDLE next edge, DONE one pulse, BUSY=0, PAUSED=0.
  - STOP+START same cycle in IDLE: no activity.
- **Async reset:** RST_N low mid-PLAY (no clock edge).
  - All outputs 0 immediately.
  - After release, nothing plays until START.
